qoi_chunk_fifo: RTL

Downstream of the qoi encoder core. Accepts variable-length encoded QOI chunks (1–5 bytes per handshake) and serialises them into a byte FIFO. The 6502 drains the FIFO through an 8-byte register window sharing the accelerator's cs/we/addr/data bus convention. This decouples encoder chunk bursts from CPU copy loops into QOI output memory.

---
 rtl/qoi_chunk_fifo_if.sv | 18 +
 rtl/qoi_chunk_fifo.sv | 128 ++++++++++++
 2 files changed

// File: rtl/qoi_chunk_fifo_if.sv
// Chunk handshake plus 6502 register-window bus for qoi_chunk_fifo.
interface qoi_chunk_fifo_if;
  logic        chunk_valid;
  logic        chunk_ready;
  logic [39:0] chunk_data;
  logic [2:0]  chunk_len;
  logic        cs;
  logic        we;
  logic [2:0]  addr;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic        irq;

  modport master (output chunk_valid, chunk_data, chunk_len, cs, we, addr, data_i,
                  input  chunk_ready, data_o, irq);
  modport slave  (input  chunk_valid, chunk_data, chunk_len, cs, we, addr, data_i,
                  output chunk_ready, data_o, irq);
endinterface

// File: rtl/qoi_chunk_fifo.sv
// Serialises 1-5 byte QOI chunks into a byte FIFO drained via an 8-byte CPU register window.
// Optional threshold interrupt: define QOI_FIFO_IRQ_EN.
module qoi_chunk_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  qoi_chunk_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][7:0] mem_q, mem_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_q, err_d, undf_q, undf_d, irq_en_q, irq_en_d;
  logic [7:0]            thresh;
  logic                  irq_pend;

  logic empty, full, legal, acc, pop_req, pop, ctrl_wr;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  // Ready looks only at registered occupancy so it never depends on chunk_len/valid.
  assign bus.chunk_ready = (count_q <= CNT_W'(DEPTH - 5));
  assign legal   = (bus.chunk_len >= 3'd1) && (bus.chunk_len <= 3'd5);
  assign acc     = bus.chunk_valid & bus.chunk_ready;
  assign pop_req = bus.cs & ~bus.we & (bus.addr == 3'd0);
  assign pop     = pop_req & ~empty;
  assign ctrl_wr = bus.cs & bus.we & (bus.addr == 3'd3);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    undf_d   = undf_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr && bus.data_i[2]) begin
      err_d  = 1'b0;
      undf_d = 1'b0;
    end
    if (acc && !legal) err_d = 1'b1;
    if (pop_req && empty) undf_d = 1'b1;
    if (acc && legal) begin
      for (int i = 0; i < 5; i++)
        if (i < int'(bus.chunk_len))
          mem_d[wr_ptr_q + AW'(i)] = bus.chunk_data[8*i +: 8];
      wr_ptr_d = wr_ptr_q + AW'(bus.chunk_len);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + ((acc && legal) ? CNT_W'(bus.chunk_len) : '0) - (pop ? CNT_W'(1) : '0);
    if (ctrl_wr) begin
      irq_en_d = bus.data_i[1];
      // Flush overrides any same-cycle accept or pop.
      if (bus.data_i[0]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      undf_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      undf_q   <= undf_d;
      irq_en_q <= irq_en_d;
    end
  end

`ifdef QOI_FIFO_IRQ_EN
  logic [7:0] thresh_q, thresh_d;
  logic       irq_q, irq_d;

  assign thresh   = thresh_q;
  assign irq_pend = irq_en_q & (16'(count_q) >= 16'(thresh_q)) & (thresh_q != 8'd0);

  always_comb begin
    thresh_d = thresh_q;
    if (bus.cs && bus.we && bus.addr == 3'd4) thresh_d = bus.data_i;
    irq_d = irq_pend;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`else
  logic unused_wdata;
  assign unused_wdata = ^bus.data_i[7:3];
  assign thresh   = 8'd0;
  assign irq_pend = 1'b0;
  assign bus.irq  = 1'b0;
`endif

  always_comb begin
    bus.data_o = 8'h00;
    case (bus.addr)
      3'd0: bus.data_o = empty ? 8'h00 : mem_q[rd_ptr_q];
      3'd1: bus.data_o = {err_q, undf_q, 3'b000, irq_pend, full, empty};
      3'd2: bus.data_o = 8'(count_q);
      3'd3: bus.data_o = {6'b0, irq_en_q, 1'b0};
      3'd4: bus.data_o = thresh;
      default: bus.data_o = 8'h00;
    endcase
  end
endmodule
